pll_cfg_ctrl: RTL

//  Upstream sequencer for pll_model. Accepts divider configs over a valid/ready handshake, drives

---
 rtl/pll_cfg_ctrl_pkg.sv | 24 ++
 rtl/pll_cfg_ctrl_lock_sync.sv | 31 +++
 rtl/pll_cfg_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_ctrl_pkg.sv
// Shared types and helpers for the PLL configuration sequencer.
package pll_cfg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    APPLY     = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    RUN       = 3'd4,
    ERROR     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ZERO_DIV = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_code_e;

  // Elaboration-time maximum, used to size the shared timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_cfg_ctrl_lock_sync.sv
// Multi-flop synchronizer bringing the PLL lock indication into the reference clock domain.
// SYNC_STAGES must be at least 2.
module lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage per edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // Synchronizer chain, cleared by reset so a stale lock cannot leak through.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_cfg_ctrl.sv
// Sequencer that loads divider settings into a PLL, waits for a synchronized and settled lock,
// then releases bypass. Retries on lock timeout and falls back to bypass on lock loss.
module pll_cfg_ctrl
  import pll_cfg_ctrl_pkg::*;
#(
  parameter int REFDIV_W      = 8,
  parameter int FBDIV_W       = 16,
  parameter int FDIV_W        = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int BLANK_CYCLES  = 8,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 64,
  parameter int MAX_RETRY     = 3
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [REFDIV_W-1:0] cfg_refdiv_i,
  input  logic [FBDIV_W-1:0]  cfg_fbdiv_i,
  input  logic [FDIV_W-1:0]   cfg_fdiv_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic                lock_i,
  output logic                bypass_o,
  output logic [REFDIV_W-1:0] refdiv_o,
  output logic [FBDIV_W-1:0]  fbdiv_o,
  output logic [FDIV_W-1:0]   fdiv_o,
  output logic                locked_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);

  localparam int TIMER_W = $clog2(max_u(LOCK_TIMEOUT, SETTLE_CYCLES) + 1);
  localparam int RETRY_W = max_u(1, $clog2(MAX_RETRY + 1));

  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
  localparam logic [TIMER_W-1:0] BLANK_T    = TIMER_W'(BLANK_CYCLES);
  localparam logic [TIMER_W-1:0] TIMEOUT_T  = TIMER_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock counts as settle cycle one, so SETTLE itself
  // needs SETTLE_CYCLES-1 further lock cycles (timer 0 .. SETTLE_CYCLES-2).
  localparam logic [TIMER_W-1:0] SETTLE_T   = TIMER_W'((SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0);
  localparam logic [RETRY_W-1:0] MAX_RETRY_T = RETRY_W'(MAX_RETRY);

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [REFDIV_W-1:0] refdiv_q, refdiv_d;
  logic [FBDIV_W-1:0]  fbdiv_q, fbdiv_d;
  logic [FDIV_W-1:0]   fdiv_q, fdiv_d;
  logic [REFDIV_W-1:0] pend_refdiv_q, pend_refdiv_d;
  logic [FBDIV_W-1:0]  pend_fbdiv_q, pend_fbdiv_d;
  logic [FDIV_W-1:0]   pend_fdiv_q, pend_fdiv_d;
  logic                bypass_q, bypass_d;
  logic                locked_q, locked_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  err_code_e           err_code_q, err_code_d;

  logic                lock_s;
  logic                accept;
  logic                cfg_zero;
  logic                take_cfg;
  logic [TIMER_W-1:0]  timer_inc;

  lock_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (lock_i),
    .q_o    (lock_s)
  );

  assign accept    = cfg_valid_i && ready_q;
  assign cfg_zero  = (cfg_refdiv_i == '0) || (cfg_fbdiv_i == '0) || (cfg_fdiv_i == '0);
  assign take_cfg  = accept && !cfg_zero;
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);

  // Next-state, counters and registered outputs; a good config always wins over lock loss.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    refdiv_d      = refdiv_q;
    fbdiv_d       = fbdiv_q;
    fdiv_d        = fdiv_q;
    pend_refdiv_d = pend_refdiv_q;
    pend_fbdiv_d  = pend_fbdiv_q;
    pend_fdiv_d   = pend_fdiv_q;
    err_d         = err_q;
    err_code_d    = err_code_q;

    if (accept) begin
      if (cfg_zero) begin
        err_d      = 1'b1;
        err_code_d = ERR_ZERO_DIV;
      end else begin
        pend_refdiv_d = cfg_refdiv_i;
        pend_fbdiv_d  = cfg_fbdiv_i;
        pend_fdiv_d   = cfg_fdiv_i;
        err_d         = 1'b0;
        err_code_d    = ERR_NONE;
        retry_d       = '0;
        timer_d       = '0;
        state_d       = APPLY;
      end
    end

    case (state_q)
      APPLY: begin
        // Dividers move one edge after bypass is already asserted.
        refdiv_d = pend_refdiv_q;
        fbdiv_d  = pend_fbdiv_q;
        fdiv_d   = pend_fdiv_q;
        timer_d  = '0;
        state_d  = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if ((timer_q >= BLANK_T) && lock_s) begin
          timer_d = '0;
          state_d = (SETTLE_CYCLES <= 1) ? RUN : SETTLE;
        end else if (timer_q >= TIMEOUT_T) begin
          if (retry_q < MAX_RETRY_T) begin
            retry_d = retry_q + RETRY_W'(1);
            timer_d = '0;
            state_d = APPLY;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ERROR;
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          // Blanking already elapsed for these dividers, so lock is trusted immediately.
          timer_d = BLANK_T;
          state_d = WAIT_LOCK;
        end else if (timer_q >= SETTLE_T) begin
          retry_d = '0;
          state_d = RUN;
        end else begin
          timer_d = timer_inc;
        end
      end
      RUN: begin
        if (!take_cfg && !lock_s) begin
          timer_d = BLANK_T;
          state_d = WAIT_LOCK;
        end
      end
      default: begin
      end
    endcase

    bypass_d = (state_d != RUN);
    locked_d = (state_d == RUN);
    busy_d   = (state_d == APPLY) || (state_d == WAIT_LOCK) || (state_d == SETTLE);
    ready_d  = (state_d == IDLE) || (state_d == RUN) || (state_d == ERROR);
  end

  // Control and output registers with asynchronous reset to the safe bypass configuration.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      refdiv_q   <= REFDIV_W'(1);
      fbdiv_q    <= FBDIV_W'(1);
      fdiv_q     <= FDIV_W'(1);
      bypass_q   <= 1'b1;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      refdiv_q   <= refdiv_d;
      fbdiv_q    <= fbdiv_d;
      fdiv_q     <= fdiv_d;
      bypass_q   <= bypass_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Pending config holding register; only read after it has been written by an accept.
  always_ff @(posedge clk_i) begin
    pend_refdiv_q <= pend_refdiv_d;
    pend_fbdiv_q  <= pend_fbdiv_d;
    pend_fdiv_q   <= pend_fdiv_d;
  end

  assign cfg_ready_o = ready_q;
  assign bypass_o    = bypass_q;
  assign refdiv_o    = refdiv_q;
  assign fbdiv_o     = fbdiv_q;
  assign fdiv_o      = fdiv_q;
  assign locked_o    = locked_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule
